// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared width, FSM state encoding and parity helper for the
//               sequential signed multiplier responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH        = 16;
    localparam int PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero-extension leaves even parity unchanged, so one fixed width serves all callers
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq_responder_dp.sv
`default_nettype none
// ============================================================================
// Module      : mult_shift_add_dp
// Description : Sign-magnitude shift-add datapath: one partial product per step,
//               WIDTH steps per multiply, two's-complement fix-up on the output.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               sign_q,   sign_d;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   shifted;

    // Unsigned magnitude; -2**(WIDTH-1) maps onto itself, which is correct unsigned
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        shifted   = {upper_sum, acc_q[WIDTH-1:0]};
        if (load_i) begin
            mcand_d  = magnitude(a_i);
            mplier_d = magnitude(b_i);
            sign_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = shifted[2*WIDTH:1];
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    assign done_o    = (cnt_q == CW'(WIDTH-1));
    assign product_o = sign_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;

endmodule
`default_nettype wire

// File: rtl/mult_seq_responder.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_responder
// Description : req/ack responder for a signed sequential multiplier with
//               operand parity checking and registered, parity-tagged result.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_responder #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [WIDTH-1:0]     arg_a,
    input  logic                 arg_a_parity,
    input  logic [WIDTH-1:0]     arg_b,
    input  logic                 arg_b_parity,
    output logic                 ack,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_parity,
    output logic                 result_rdy,
    output logic                 arg_parity_error
);

    import mult_pkg::*;

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic               rdy_q, rdy_d;
    logic               perr_q, perr_d;
    logic               err_q, err_d;
    logic               rpar_q, rpar_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dp_load, dp_step, dp_done;
    logic [2*WIDTH-1:0] dp_product;
    logic               operand_bad;

    assign operand_bad = (arg_a_parity != calc_parity(PARITY_MAX_W'(arg_a)))
                       | (arg_b_parity != calc_parity(PARITY_MAX_W'(arg_b)));

    mult_shift_add_dp #(
        .WIDTH     (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (dp_load),
        .step_i    (dp_step),
        .a_i       (arg_a),
        .b_i       (arg_b),
        .done_o    (dp_done),
        .product_o (dp_product)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rdy_d    = 1'b0;
        perr_d   = perr_q;
        err_d    = err_q;
        rpar_d   = rpar_q;
        result_d = result_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    dp_load = 1'b1;
                    ack_d   = 1'b1;
                    perr_d  = operand_bad;
                    state_d = operand_bad ? DONE : CALC;
                end
            end
            CALC: begin
                dp_step = 1'b1;
                if (dp_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Output registers load here, so result_rdy lands the cycle after DONE
                rdy_d   = 1'b1;
                state_d = IDLE;
                if (perr_q) begin
                    result_d = '0;
                    rpar_d   = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    result_d = dp_product;
                    rpar_d   = calc_parity(PARITY_MAX_W'(dp_product));
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
            perr_q   <= 1'b0;
            err_q    <= 1'b0;
            rpar_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            perr_q   <= perr_d;
            err_q    <= err_d;
            rpar_q   <= rpar_d;
            result_q <= result_d;
        end
    end

    assign ack              = ack_q;
    assign result_rdy       = rdy_q;
    assign arg_parity_error = err_q;
    assign result_parity    = rpar_q;
    assign result           = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_responder
// Description : Directed self-checking bench for mult_seq_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic [15:0] arg_a;
    logic        arg_a_parity;
    logic [15:0] arg_b;
    logic        arg_b_parity;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        result_rdy;
    logic        arg_parity_error;

    int tests_run;
    int tests_failed;

    mult_seq_responder #(.WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .result_rdy       (result_rdy),
        .arg_parity_error (arg_parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: returns edges-to-ack, edges from ack to result_rdy, and acks seen meanwhile
    task automatic run_op(input logic [15:0] a, input logic ap, input logic [15:0] b, input logic bp,
                          output int ack_wait, output int lat, output int extra_ack);
        arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
        ack_wait = -1; lat = -1; extra_ack = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack) begin ack_wait = i; break; end
        end
        req = 1'b0;
        if (ack_wait >= 0) begin
            for (int i = 1; i <= 60; i++) begin
                tick();
                if (ack) extra_ack++;
                if (result_rdy) begin lat = i; break; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tests_run++;
        if (ack !== 1'b0 || result_rdy !== 1'b0 || arg_parity_error !== 1'b0 ||
            result_parity !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b rdy=%b err=%b par=%b result=%h, required all 0",
                     ack, result_rdy, arg_parity_error, result_parity, result);
        end
        tick();
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_ack: ack=%b, required 0", ack);
        end
    endtask

    task automatic test_valid_product();
        int aw, lat, ex;
        run_op(16'd3, 1'b0, 16'hFFFB, 1'b1, aw, lat, ex);
        tests_run++;
        if (aw !== 0) begin
            tests_failed++;
            $display("FAIL valid_ack_timing: ack after %0d edges, required 0", aw);
        end
        tests_run++;
        if (lat !== 17 || ex !== 0) begin
            tests_failed++;
            $display("FAIL valid_latency: latency=%0d extra_ack=%0d, required 17 and 0", lat, ex);
        end
        tests_run++;
        if (result !== 32'hFFFF_FFF1 || result_parity !== 1'b1 || arg_parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_result: result=%h par=%b err=%b, required fffffff1 1 0",
                     result, result_parity, arg_parity_error);
        end
        tick();
        tests_run++;
        if (result_rdy !== 1'b0 || result !== 32'hFFFF_FFF1 || result_parity !== 1'b1) begin
            tests_failed++;
            $display("FAIL valid_hold: rdy=%b result=%h par=%b, required 0 fffffff1 1",
                     result_rdy, result, result_parity);
        end
    endtask

    task automatic test_extremes();
        int aw, lat, ex;
        run_op(16'h8000, 1'b1, 16'h8000, 1'b1, aw, lat, ex);
        tests_run++;
        if (lat !== 17 || result !== 32'h4000_0000 || result_parity !== 1'b1 || arg_parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL min_times_min: lat=%0d result=%h par=%b err=%b, required 17 40000000 1 0",
                     lat, result, result_parity, arg_parity_error);
        end
        tick();
        run_op(16'h8000, 1'b1, 16'h7FFF, 1'b1, aw, lat, ex);
        tests_run++;
        if (lat !== 17 || result !== 32'hC000_8000 || result_parity !== 1'b1) begin
            tests_failed++;
            $display("FAIL min_times_max: lat=%0d result=%h par=%b, required 17 c0008000 1",
                     lat, result, result_parity);
        end
    endtask

    task automatic test_parity_error();
        int aw, lat, ex;
        tick();
        run_op(16'd1, 1'b0, 16'd7, 1'b1, aw, lat, ex);
        tests_run++;
        if (aw !== 0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL perr_latency: ack_wait=%0d latency=%0d, required 0 and 1", aw, lat);
        end
        tests_run++;
        if (arg_parity_error !== 1'b1 || result !== 32'h0 || result_parity !== 1'b0) begin
            tests_failed++;
            $display("FAIL perr_outputs: err=%b result=%h par=%b, required 1 00000000 0",
                     arg_parity_error, result, result_parity);
        end
    endtask

    task automatic test_reset_mid_calc();
        int aw, lat, ex;
        int seen_rdy;
        tick();
        arg_a = 16'd9; arg_a_parity = 1'b0; arg_b = 16'd9; arg_b_parity = 1'b0; req = 1'b1;
        aw = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack) begin aw = i; break; end
        end
        req = 1'b0;
        tests_run++;
        if (aw !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_ack: ack after %0d edges, required 0", aw);
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (ack !== 1'b0 || result_rdy !== 1'b0 || arg_parity_error !== 1'b0 ||
            result_parity !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: ack=%b rdy=%b err=%b par=%b result=%h, required all 0",
                     ack, result_rdy, arg_parity_error, result_parity, result);
        end
        seen_rdy = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (result_rdy) seen_rdy++;
        end
        tests_run++;
        if (seen_rdy !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_no_rdy: result_rdy pulses=%0d, required 0", seen_rdy);
        end
        run_op(16'd2, 1'b1, 16'd3, 1'b0, aw, lat, ex);
        tests_run++;
        if (lat !== 17 || result !== 32'd6 || result_parity !== 1'b0 || arg_parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_followup: lat=%0d result=%h par=%b err=%b, required 17 00000006 0 0",
                     lat, result, result_parity, arg_parity_error);
        end
    endtask

    task automatic test_back_to_back();
        int aw, lat, ex;
        tick();
        arg_a = 16'd0; arg_a_parity = 1'b0; arg_b = 16'd12345; arg_b_parity = 1'b0; req = 1'b1;
        aw = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack) begin aw = i; break; end
        end
        lat = -1; ex = 0;
        if (aw >= 0) begin
            for (int i = 1; i <= 60; i++) begin
                tick();
                if (i == 2) begin
                    arg_a = 16'd100; arg_a_parity = 1'b1; arg_b = 16'hFFFE; arg_b_parity = 1'b1;
                end
                if (ack) ex++;
                if (result_rdy) begin lat = i; break; end
            end
        end
        tests_run++;
        if (lat !== 17 || ex !== 0 || result !== 32'h0 || result_parity !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d extra_ack=%0d result=%h par=%b, required 17 0 00000000 0",
                     lat, ex, result, result_parity);
        end
        tick();
        tests_run++;
        if (ack !== 1'b1 || result_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_ack: ack=%b rdy=%b, required 1 0", ack, result_rdy);
        end
        req = 1'b0;
        lat = -1; ex = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (ack) ex++;
            if (result_rdy) begin lat = i; break; end
        end
        tests_run++;
        if (lat !== 17 || ex !== 0 || result !== 32'hFFFF_FF38 || result_parity !== 1'b1 ||
            arg_parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d extra_ack=%0d result=%h par=%b err=%b, required 17 0 ffffff38 1 0",
                     lat, ex, result, result_parity, arg_parity_error);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_valid_product();
        test_extremes();
        test_parity_error();
        test_reset_mid_calc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
